// File: rtl/hog_det_collector.sv
// hog_det_collector: maps classifier results to window (x,y), queues positives in a FWFT FIFO, reports frame stats.
// Optional HOG_DET_SCORE_EN adds i_score/o_score carried per FIFO entry.
module hog_det_collector #(
  parameter int SW_W   = 11,
  parameter int SW_COL = 37,
  parameter int SW_ROW = 25,
  parameter int DEPTH  = 16,
  parameter int X_W    = 6,
  parameter int Y_W    = 5,
  parameter int FEA_W  = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_valid,
  input  logic                     is_person,
  input  logic [SW_W-1:0]          sw_id,
`ifdef HOG_DET_SCORE_EN
  input  logic [FEA_W-1:0]         i_score,
  output logic [FEA_W-1:0]         o_score,
`endif
  input  logic                     rd_en,
  input  logic                     clr,
  output logic                     o_valid,
  output logic [X_W-1:0]           o_x,
  output logic [Y_W-1:0]           o_y,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     frame_done,
  output logic [SW_W-1:0]          frame_cnt,
  output logic                     overflow,
  output logic [7:0]               drop_cnt,
  output logic                     seq_err
);
  localparam int AW = $clog2(DEPTH);
`ifdef HOG_DET_SCORE_EN
  localparam int SC_W = FEA_W;
`else
  localparam int SC_W = 0;
`endif
  localparam int EW = Y_W + X_W + SC_W;
  localparam logic [SW_W-1:0] LAST = SW_W'(SW_COL * SW_ROW - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [X_W-1:0] col, col_nxt, cur_col;
  logic [Y_W-1:0] row, row_nxt, cur_row;
  logic [SW_W-1:0] exp_id, exp_nxt, det_cnt, det_nxt, cur_det;
  logic start, match, restart, bad, proc, zero_base, push;
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] wdata, head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] level;
  logic pop, wr, drop;
  // a frame (re)start always processes its first window at (0,0) with a fresh count
  always_comb begin
    start     = i_valid && sw_id == '0 && state != RUN;
    match     = i_valid && state == RUN && sw_id == exp_id;
    restart   = i_valid && state == RUN && sw_id != exp_id && sw_id == '0;
    bad       = i_valid && state == RUN && sw_id != exp_id && sw_id != '0;
    proc      = start || match || restart;
    zero_base = start || restart;
    cur_col   = zero_base ? '0 : col;
    cur_row   = zero_base ? '0 : row;
    cur_det   = zero_base ? '0 : det_cnt;
    push      = proc && is_person;
    col_nxt   = cur_col == X_W'(SW_COL - 1) ? '0 : cur_col + 1'b1;
    row_nxt   = cur_col == X_W'(SW_COL - 1) ? cur_row + 1'b1 : cur_row;
    exp_nxt   = sw_id + 1'b1;
    det_nxt   = cur_det + SW_W'(is_person);
    state_nxt = proc ? (sw_id == LAST ? DONE : RUN) : (bad || state == DONE) ? IDLE : state;
  end
`ifdef HOG_DET_SCORE_EN
  assign wdata   = {i_score, cur_row, cur_col};
  assign o_score = o_valid ? head[X_W+Y_W+:FEA_W] : '0;
`else
  assign wdata = {cur_row, cur_col};
`endif
  assign head       = mem[rd_ptr];
  assign o_valid    = level != '0;
  assign o_x        = o_valid ? head[X_W-1:0] : '0;
  assign o_y        = o_valid ? head[X_W+:Y_W] : '0;
  assign o_level    = level;
  assign frame_done = state == DONE;
  assign pop        = rd_en && o_valid;
  assign wr         = push && (level != (AW+1)'(DEPTH) || pop);
  assign drop       = push && !wr;
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= wdata;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      exp_id    <= '0;
      det_cnt   <= '0;
      frame_cnt <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      seq_err   <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (proc) begin
        col     <= col_nxt;
        row     <= row_nxt;
        exp_id  <= exp_nxt;
        det_cnt <= det_nxt;
      end else if (bad || state == DONE) begin
        col     <= '0;
        row     <= '0;
        exp_id  <= '0;
        det_cnt <= '0;
      end
      if (state == DONE) frame_cnt <= det_cnt;
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      level    <= level + (AW+1)'(wr) - (AW+1)'(pop);
      overflow <= drop || (overflow && !clr);
      seq_err  <= bad || restart || (seq_err && !clr);
      drop_cnt <= clr ? 8'(drop) : drop_cnt + 8'(drop && drop_cnt != 8'hff);
    end
  end
endmodule

// File: tb/tb_hog_det_collector.sv
// tb_hog_det_collector: directed and random stimulus against a sw_id-level reference model.
module tb_hog_det_collector;
  localparam int COL = 37, ROWS = 25, TOTAL = COL * ROWS, DEPTH = 16;
  logic clk = 0, rst = 1, i_valid = 0, is_person = 0, rd_en = 0, clr = 0;
  logic [10:0] sw_id = '0;
  logic o_valid, frame_done, overflow, seq_err;
  logic [5:0] o_x;
  logic [4:0] o_y, o_level;
  logic [10:0] frame_cnt;
  logic [7:0] drop_cnt;
  int checks = 0, errors = 0;
  int q[$];
  bit m_run, m_done, m_ovf, m_serr;
  int m_exp, m_det, m_fcnt, m_dcnt;

  hog_det_collector dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .is_person(is_person), .sw_id(sw_id),
    .rd_en(rd_en), .clr(clr), .o_valid(o_valid), .o_x(o_x), .o_y(o_y), .o_level(o_level),
    .frame_done(frame_done), .frame_cnt(frame_cnt), .overflow(overflow),
    .drop_cnt(drop_cnt), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("o_valid", o_valid, q.size() > 0);
    chk("o_level", o_level, q.size());
    chk("o_x", o_x, q.size() > 0 ? q[0] % COL : 0);
    chk("o_y", o_y, q.size() > 0 ? q[0] / COL : 0);
    chk("frame_done", frame_done, m_done);
    chk("frame_cnt", frame_cnt, m_fcnt);
    chk("overflow", overflow, m_ovf);
    chk("drop_cnt", drop_cnt, m_dcnt);
    chk("seq_err", seq_err, m_serr);
  endtask

  task automatic model_reset();
    q.delete();
    m_run = 0; m_done = 0; m_ovf = 0; m_serr = 0;
    m_exp = 0; m_det = 0; m_fcnt = 0; m_dcnt = 0;
  endtask

  task automatic model_step(input bit v, input bit p, input int id, input bit rd, input bit c);
    bit go, push, pop, drop, err;
    int sz;
    go = 0; push = 0; drop = 0; err = 0;
    sz = q.size();
    if (m_done) begin
      m_fcnt = m_det;
      m_det = 0;
    end
    m_done = 0;
    if (v) begin
      if (m_run && id == m_exp) go = 1;
      else if (id == 0) begin
        err = m_run;
        m_det = 0;
        go = 1;
      end else if (m_run) begin
        err = 1;
        m_run = 0;
        m_det = 0;
      end
      if (go) begin
        push = p;
        m_det += int'(p);
        m_exp = id + 1;
        m_run = id != TOTAL - 1;
        m_done = id == TOTAL - 1;
      end
    end
    pop = rd && sz > 0;
    if (pop) void'(q.pop_front());
    if (push) begin
      if (sz < DEPTH || pop) q.push_back(id);
      else drop = 1;
    end
    m_ovf = drop || (m_ovf && !c);
    m_dcnt = c ? int'(drop) : (m_dcnt + int'(drop) > 255 ? 255 : m_dcnt + int'(drop));
    m_serr = err || (m_serr && !c);
  endtask

  task automatic step(input bit v, input bit p, input int id, input bit rd, input bit c);
    i_valid = v; is_person = p; sw_id = 11'(id); rd_en = rd; clr = c;
    @(posedge clk);
    model_step(v, p, id, rd, c);
    #1;
    check_all();
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst = 0;
    // full frame with three positives
    for (int i = 0; i < TOTAL; i++) step(1, i == 0 || i == 38 || i == 924, i, 0, 0);
    chk("done_pulse", frame_done, 1);
    step(0, 0, 0, 0, 0);
    chk("done_single", frame_done, 0);
    chk("frame_cnt_3", frame_cnt, 3);
    chk("head_0_0", {o_y, o_x}, {5'd0, 6'd0});
    step(0, 0, 0, 1, 0);
    chk("head_1_1", {o_y, o_x}, {5'd1, 6'd1});
    step(0, 0, 0, 1, 0);
    chk("head_36_24", {o_y, o_x}, {5'd24, 6'd36});
    step(0, 0, 0, 1, 0);
    chk("drained", o_valid, 0);
    // fill, push+pop while full, then overflow
    for (int i = 0; i < TOTAL; i++) begin
      step(1, i < 24, i, i >= 16 && i < 20, 0);
      if (i == 19) begin
        chk("full_pushpop_level", o_level, 16);
        chk("full_pushpop_ovf", overflow, 0);
      end
      if (i == 23) begin
        chk("ovf_set", overflow, 1);
        chk("ovf_drops", drop_cnt, 4);
        chk("ovf_level", o_level, 16);
      end
    end
    step(0, 0, 0, 0, 0);
    chk("frame_cnt_24", frame_cnt, 24);
    chk("head_after_pp", o_x, 4);
    repeat (16) step(0, 0, 0, 1, 0);
    chk("drain_level", o_level, 0);
    step(0, 0, 0, 0, 1);
    chk("clr_ovf", overflow, 0);
    chk("clr_drop", drop_cnt, 0);
    // sequence jump 0,1,2,5
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0);
    step(1, 0, 2, 0, 0);
    step(1, 1, 5, 0, 0);
    chk("jump_seq_err", seq_err, 1);
    chk("jump_no_push", o_level, 0);
    step(1, 1, 3, 0, 0);
    chk("idle_ignores", o_level, 0);
    step(1, 1, 0, 0, 0);
    chk("restart_level", o_level, 1);
    chk("restart_xy", {o_y, o_x}, 11'd0);
    step(0, 0, 0, 1, 1);
    chk("clr_seq_err", seq_err, 0);
    // sw_id 0 arriving at exp_id 100
    for (int i = 1; i < 100; i++) step(1, 0, i, 0, 0);
    step(1, 1, 0, 0, 0);
    chk("mid_restart_err", seq_err, 1);
    chk("mid_restart_push", o_level, 1);
    for (int i = 1; i < TOTAL; i++) step(1, 0, i, 0, 0);
    step(0, 0, 0, 1, 1);
    chk("mid_restart_fcnt", frame_cnt, 1);
    // reset with five entries queued
    for (int i = 0; i < 5; i++) step(1, 1, i, 0, 0);
    chk("pre_rst_level", o_level, 5);
    i_valid = 0; is_person = 0; rd_en = 0; clr = 0;
    rst = 1;
    @(posedge clk);
    model_reset();
    #1;
    check_all();
    rst = 0;
    step(1, 1, 5, 0, 0);
    chk("post_rst_needs_0", o_level, 0);
    step(1, 1, 0, 0, 0);
    chk("post_rst_start", o_level, 1);
    // random traffic
    for (int k = 0; k < 6000; k++) begin
      int r, id;
      bit v, p, rd, c;
      r = $urandom_range(999);
      id = (r < 2) ? $urandom_range(TOTAL - 1) : (r < 4) ? 0 : (m_run ? m_exp : 0);
      v = $urandom_range(99) < 85;
      p = $urandom_range(99) < 30;
      rd = $urandom_range(99) < (k < 3000 ? 15 : 45);
      c = $urandom_range(99) < 3;
      step(v, p, id, rd, c);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hog_det_collector.md
Name: hog_det_collector

Overview:
Downstream stage of the HOG+SVM top. Consumes the per-window classifier output (i_valid, is_person, sw_id) and converts each slide-window index to (x, y) window coordinates with internal row/column counters. It buffers positive detections in a first-word-fall-through FIFO for the host and reports per-frame detection counts, frame completion and error flags.

Parameters:
SW_W, 11, slide-window index width; must match the SVM stage
SW_COL, 37, slide windows per row
SW_ROW, 25, slide-window rows per frame; SW_COL*SW_ROW <= 2**SW_W
DEPTH, 16, detection FIFO depth, power of 2
X_W, 6, x coordinate width, >= clog2(SW_COL)
Y_W, 5, y coordinate width, >= clog2(SW_ROW)
FEA_W, 20, score width; used only with HOG_DET_SCORE_EN

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active high
i_valid  in  1  classifier result valid; single-cycle strobe per window
is_person  in  1  window classified positive
sw_id  in  SW_W  slide-window index of the current result
rd_en  in  1  host pop of the FIFO head
clr  in  1  synchronous clear of sticky flags and drop counter
o_valid  out  1  FIFO not empty; head is valid
o_x  out  X_W  head entry window column
o_y  out  Y_W  head entry window row
o_level  out  clog2(DEPTH)+1  FIFO occupancy
frame_done  out  1  one-cycle pulse after the last window of a frame
frame_cnt  out  SW_W  positives in the last completed frame, including dropped ones
overflow  out  1  sticky; a positive was dropped because the FIFO was full
drop_cnt  out  8  saturating count of dropped positives
seq_err  out  1  sticky; sw_id did not match the expected index

Behaviour:
- Reset: all outputs 0, FIFO empty, state IDLE, counters col/row/exp_id/det_cnt at 0.
- Expected index exp_id increments on each accepted i_valid. Column col wraps at SW_COL-1 to 0 and increments row.
- FSM:
  - IDLE: ignore i_valid unless sw_id==0. On i_valid with sw_id==0, process the window as (0,0) and go to RUN.
  - RUN: on i_valid with sw_id==exp_id, process the window. If sw_id==SW_COL*SW_ROW-1, go to DONE.
  - RUN, mismatch: on i_valid with sw_id!=exp_id, set seq_err and go to IDLE. The window is discarded, no frame_done is pulsed, and det_cnt and counters are cleared.
  - RUN, mismatch with sw_id==0: set seq_err and restart the frame directly in RUN at (0,0). That window is processed.
  - DONE: single cycle. frame_done=1, frame_cnt<=det_cnt, counters and det_cnt cleared, go to IDLE. An i_valid in DONE is handled as if in IDLE.
- Processing a window: if is_person, det_cnt++ and attempt a push of {row, col}.
- Latency: i_valid at cycle N gives the entry visible on o_valid/o_x/o_y at N+1. frame_done pulses at N+1 for the last window.
- FIFO (first-word fall-through): the head is always on o_x/o_y when o_valid=1.
  - rd_en while empty: ignored.
  - Push while full without pop: dropped; overflow<=1, drop_cnt++ saturating at 255.
  - Push and pop in the same cycle while full: both succeed, level unchanged.
  - Push and pop while empty: push only.
  - Pointers wrap modulo DEPTH.
- clr clears overflow, seq_err and drop_cnt only. clr in the same cycle as a new error: the error wins (flag set).
- Reset mid-frame: the FIFO contents are lost and the FSM returns to IDLE.

Optional Feature:
HOG_DET_SCORE_EN: when defined, adds input i_score [FEA_W] and output o_score [FEA_W]. The score is stored per FIFO entry alongside x/y and follows the same latency. o_score resets to 0. When undefined, the ports and storage are absent and behaviour is otherwise identical.

Test Plan:
- Full frame of 925 windows, is_person at sw_id 0, 38, 924 -> FIFO pops (0,0), (1,1), (36,24); frame_done single pulse the cycle after sw_id 924; frame_cnt=3.
- 20 consecutive positives, no rd_en -> o_level=16, overflow=1, drop_cnt=4, frame_cnt counts 20 at frame end; pops return the first 16 in order.
- FIFO full with simultaneous push and pop -> o_level stays 16, overflow stays 0, order preserved.
- sw_id jumps 0,1,2,5 -> seq_err=1 at 5, no push, no frame_done. A later sw_id=0 restarts at (0,0). clr then clears seq_err.
- sw_id=0 arrives mid-frame at exp_id=100 -> seq_err=1, frame restarts in RUN at (0,0), entry pushed if is_person.
- Assert rst while o_level=5 mid-frame -> all outputs 0 next edge; first window after release needs sw_id=0.
